// File: rtl/dot32_serial_mac.sv
// dot32_serial_mac
//   Serial 32-term unsigned dot product. The 128-bit input vector holds
//   32 unsigned 4-bit elements (element n = I[127-4n -: 4]). The weight
//   vector W uses the same packing. One accepted request is processed
//   as four 8-element chunks, in order 0..3, one chunk per clock. The
//   13-bit result is presented for one cycle.
//
//   Ports
//     clk          rising-edge clock
//     rst_n        asynchronous active-low reset
//     in_valid     request: latch I and start a computation (IDLE/DONE only)
//     weight_valid load W into the weight register (IDLE/DONE only)
//     I[127:0]     32 x 4-bit unsigned inputs
//     W[127:0]     32 x 4-bit unsigned weights
//     out_valid    OUT carries a result this cycle
//     OUT[12:0]    unsigned dot product, 0 whenever out_valid is low
//
//   Build option
//     WEIGHT_HOLD_EN  when defined, weights persist across computations.
//                     When undefined, the weight register is cleared on the
//                     edge that finishes a computation.
module dot32_serial_mac (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  input  logic         weight_valid,
  input  logic [127:0] I,
  input  logic [127:0] W,
  output logic         out_valid,
  output logic [12:0]  OUT
);

  localparam int DATA_W  = 4;
  localparam int COEF_W  = 4;
  localparam int PROD_W  = DATA_W + COEF_W;
  localparam int CHUNK_W = PROD_W + 3;
  localparam int ACC_W   = 13;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [127:0]       in_reg;
  logic [127:0]       w_reg;
  logic [ACC_W-1:0]   acc;
  logic [1:0]         cnt;

  logic [31:0]        in_chunk;
  logic [31:0]        w_chunk;
  logic [CHUNK_W-1:0] chunk_sum;
  logic [ACC_W-1:0]   acc_next;

  // Sum of eight 4x4 unsigned products. Element 0 of the chunk sits in
  // the most significant nibble.
  function automatic logic [CHUNK_W-1:0] sum8(input logic [31:0] a,
                                              input logic [31:0] b);
    logic [CHUNK_W-1:0] s;
    logic [PROD_W-1:0]  p;
    s = '0;
    for (int k = 0; k < 8; k++) begin
      p = PROD_W'(a[31-4*k -: 4]) * PROD_W'(b[31-4*k -: 4]);
      s = s + CHUNK_W'(p);
    end
    return s;
  endfunction

  // Chunk c covers elements 8c..8c+7, i.e. the c-th 32-bit slice from the top.
  always_comb begin
    in_chunk = in_reg[127:96];
    w_chunk  = w_reg[127:96];
    case (cnt)
      2'd0: begin in_chunk = in_reg[127:96]; w_chunk = w_reg[127:96]; end
      2'd1: begin in_chunk = in_reg[95:64];  w_chunk = w_reg[95:64];  end
      2'd2: begin in_chunk = in_reg[63:32];  w_chunk = w_reg[63:32];  end
      default: begin in_chunk = in_reg[31:0]; w_chunk = w_reg[31:0]; end
    endcase
  end

  assign chunk_sum = sum8(in_chunk, w_chunk);
  assign acc_next  = acc + ACC_W'(chunk_sum);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_reg    <= '0;
      w_reg     <= '0;
      acc       <= '0;
      cnt       <= '0;
      out_valid <= 1'b0;
      OUT       <= '0;
    end else begin
      case (state)
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
            state     <= DONE;
            out_valid <= 1'b1;
            OUT       <= acc_next;
`ifdef WEIGHT_HOLD_EN
            w_reg     <= w_reg;
`else
            w_reg     <= '0;
`endif
          end
        end
        default: begin
          // IDLE and DONE behave alike: the result pulse ends here and a
          // new request may be accepted back-to-back.
          out_valid <= 1'b0;
          OUT       <= '0;
          if (weight_valid) begin
            w_reg <= W;
          end
          if (in_valid) begin
            in_reg <= I;
            acc    <= '0;
            cnt    <= '0;
            state  <= CALC;
          end else begin
            state  <= IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot32_serial_mac.sv
module tb_dot32_serial_mac;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         weight_valid;
  logic [127:0] I;
  logic [127:0] W;
  logic         out_valid;
  logic [12:0]  OUT;

  always #5 clk = ~clk;

  dot32_serial_mac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .weight_valid (weight_valid),
    .I            (I),
    .W            (W),
    .out_valid    (out_valid),
    .OUT          (OUT)
  );

  typedef struct {
    logic [127:0] i;
    logic [127:0] w;
    int           exp;
  } vec_t;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int pulses   = 0;
  int last_pulse = -1;
  int exp_q[$];
  int acc_q[$];

`ifdef WEIGHT_HOLD_EN
  localparam int HOLD_64 = 64;
`else
  localparam int HOLD_64 = 0;
`endif

  function automatic void check(input string nm, input int act, input int req);
    n_checks++;
    if (act == req) n_pass++;
    else $display("FAIL %s: got %0d, required %0d (cycle %0d)", nm, act, req, cyc);
  endfunction

  function automatic logic [127:0] rep(input logic [3:0] nib);
    logic [127:0] r;
    r = {32{nib}};
    return r;
  endfunction

  function automatic int ref_dot(input logic [127:0] a, input logic [127:0] b);
    int s;
    s = 0;
    for (int n = 0; n < 32; n++)
      s += int'(a[127-4*n -: 4]) * int'(b[127-4*n -: 4]);
    return s;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every out_valid cycle pops one expectation; OUT must be 0 otherwise.
  always @(negedge clk) begin
    if (out_valid) begin
      pulses++;
      last_pulse = cyc;
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_pulse: got out_valid=1 OUT=%0d, required no pulse (cycle %0d)", OUT, cyc);
      end else begin
        check("out_value", int'(OUT), exp_q.pop_front());
        check("out_latency", cyc, acc_q.pop_front() + 4);
      end
    end else begin
      check("out_zero_when_invalid", int'(OUT), 0);
    end
  end

  // Called at a falling edge; request is accepted on the next rising edge.
  task automatic drive_req(input logic [127:0] iv, input logic [127:0] wv_data,
                           input logic wv, input int expv);
    I            = iv;
    W            = wv_data;
    in_valid     = 1'b1;
    weight_valid = wv;
    exp_q.push_back(expv);
    acc_q.push_back(cyc + 1);
    @(negedge clk);
    in_valid     = 1'b0;
    weight_valid = 1'b0;
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 30; k++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk);
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL drain_timeout: got %0d pending results, required 0", exp_q.size());
      exp_q.delete();
      acc_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t         vecs[6];
    logic [127:0] ramp;
    logic [127:0] ri;
    logic [127:0] rw;
    int           p0;
    int           first_p;

    for (int n = 0; n < 32; n++) ramp[127-4*n -: 4] = 4'(n % 16);
    for (int n = 0; n < 4; n++) begin
      ri[127-32*n -: 32] = $urandom;
      rw[127-32*n -: 32] = $urandom;
    end
    vecs[0] = '{rep(4'h1), rep(4'h1), 32};
    vecs[1] = '{rep(4'hF), rep(4'hF), 7200};
    vecs[2] = '{rep(4'h0), rep(4'hA), 0};
    vecs[3] = '{ramp, rep(4'h1), 240};
    vecs[4] = '{rep(4'h1), ramp, 240};
    vecs[5] = '{ri, rw, ref_dot(ri, rw)};

    rst_n = 1'b0; in_valid = 1'b0; weight_valid = 1'b0; I = '0; W = '0;
    #2;
    check("reset_out", int'(OUT), 0);
    check("reset_out_valid", int'(out_valid), 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 6; v++) begin
      drive_req(vecs[v].i, vecs[v].w, 1'b1, vecs[v].exp);
      wait_drain();
    end

    // Weight reuse with in_valid only
    drive_req(rep(4'h3), rep(4'h2), 1'b1, 192);
    wait_drain();
    drive_req(rep(4'h1), rep(4'hF), 1'b0, HOLD_64);
    wait_drain();

    // Request pulse during CALC must be ignored, including its W
    repeat (2) @(negedge clk);
    p0 = pulses;
    drive_req(rep(4'h1), rep(4'h1), 1'b1, 32);
    I = rep(4'hF); W = rep(4'hF); in_valid = 1'b1; weight_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; weight_valid = 1'b0;
    wait_drain();
    repeat (6) @(negedge clk);
    check("single_pulse_calc_ignore", pulses - p0, 1);
    drive_req(rep(4'h2), rep(4'h0), 1'b0, HOLD_64);
    wait_drain();

    // Reset two edges after accept aborts the computation
    repeat (2) @(negedge clk);
    p0 = pulses;
    drive_req(rep(4'h1), rep(4'h1), 1'b1, 32);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    acc_q.delete();
    #1;
    check("async_reset_out_valid", int'(out_valid), 0);
    check("async_reset_out", int'(OUT), 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no_pulse_after_abort", pulses - p0, 0);
    drive_req(rep(4'h5), rep(4'hF), 1'b0, 0);
    wait_drain();
    drive_req(rep(4'hF), rep(4'h1), 1'b1, 480);
    wait_drain();

    // Back-to-back: second request accepted while in DONE
    repeat (2) @(negedge clk);
    drive_req(rep(4'h1), rep(4'h2), 1'b1, 64);
    first_p = -100;
    for (int k = 0; k < 20; k++) begin
      if (out_valid) begin
        first_p = cyc;
        break;
      end
      @(negedge clk);
    end
    drive_req(rep(4'h3), rep(4'h3), 1'b1, 288);
    wait_drain();
    check("b2b_spacing", last_pulse - first_p, 5);

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/dot32_serial_mac.md
DOT32_SERIAL_MAC -- requirements
Module: dot32_serial_mac

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single rising-edge clock.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-003 The block SHALL have the port in_valid, input, 1 bit: I is valid this cycle and a computation is requested.
REQ-004 The block SHALL have the port weight_valid, input, 1 bit: W is valid this cycle and is loaded into the weight register.
REQ-005 The block SHALL have the port I, input, 128 bits: 32 unsigned 4-bit inputs, element n = I[127-4n -: 4], n = 0..31.
REQ-006 The block SHALL have the port W, input, 128 bits: 32 unsigned 4-bit weights, same packing as I.
REQ-007 The block SHALL have the port out_valid, output, 1 bit: OUT holds a result this cycle.
REQ-008 The block SHALL have the port OUT, output, 13 bits: unsigned dot product sum(I[n]*W[n]).

Function
REQ-009 The block SHALL implement the states IDLE, CALC and DONE.
REQ-010 In IDLE or DONE, in_valid=1 at a rising edge SHALL latch I into the input register, clear the accumulator, set chunk counter=0 and enter CALC.
REQ-011 weight_valid=1 at a rising edge while the state is IDLE or DONE SHALL load W into the weight register, with or without in_valid; the computation started on the same edge SHALL use the new W.
REQ-012 In CALC, each rising edge SHALL add the 8 products of chunk c (elements 8c..8c+7) to the accumulator and increment c; chunks SHALL be processed in the order 0,1,2,3.
REQ-013 The edge that adds chunk 3 SHALL enter DONE; out_valid SHALL be 1 for exactly the one cycle following the 4th rising edge after the accepting edge.
REQ-014 OUT SHALL equal the full 32-term sum while out_valid=1, and SHALL be 0 whenever out_valid=0.
REQ-015 The accumulator SHALL be 13-bit unsigned; the maximum 32*15*15=7200 fits, so no saturation or wrap logic is required.
REQ-016 In_valid and weight_valid SHALL be ignored in CALC; I, W and the registers SHALL be unaffected.
REQ-017 If in_valid is low in DONE, the state SHALL go to IDLE on the next edge; if high, the request SHALL be accepted back-to-back per REQ-010.
REQ-018 Each multiplier SHALL be 4x4 to 8-bit unsigned; the 8-term adder tree SHALL be at least 11 bits wide.

Reset
REQ-019 rst_n=0 SHALL immediately force state IDLE, out_valid=0, OUT=0, accumulator=0, counter=0, and input and weight registers=0, independent of clk.
REQ-020 Reset asserted during CALC SHALL abort the computation; no out_valid SHALL follow for the aborted request.
REQ-021 The first in_valid edge after rst_n rises SHALL be accepted normally.

Configuration
REQ-022 With macro WEIGHT_HOLD_EN defined, the weight register SHALL retain its value across computations, and in_valid without weight_valid SHALL reuse the last loaded weights.
REQ-023 Without WEIGHT_HOLD_EN, the weight register SHALL be cleared to 0 on the edge entering DONE, and in_valid without weight_valid SHALL produce OUT=0.

Verification
REQ-024 The bench SHALL cover this case: after reset, check OUT=0 and out_valid=0 before any clock edge; in_valid=weight_valid=1 with all I=1 and all W=1 -> out_valid for 1 cycle 4 edges later with OUT=32.
REQ-025 The bench SHALL cover this case: all I=F and all W=F -> OUT=7200; all I=0 with any W -> OUT=0.
REQ-026 The bench SHALL cover this case: all W=2 and all I=3 with both valids -> OUT=192; next request with in_valid only and all I=1 -> OUT=64 with WEIGHT_HOLD_EN, OUT=0 without it.
REQ-027 The bench SHALL cover this case: in_valid pulse with W=F during CALC -> ignored; the result of the original request is unchanged and only one out_valid pulse occurs.
REQ-028 The bench SHALL cover this case: rst_n pulsed low 2 edges after accept -> no out_valid pulse; a new request after reset gives the correct sum.
REQ-029 The bench SHALL cover this case: back-to-back requests, with in_valid asserted during DONE -> the second out_valid appears exactly 5 cycles after the first.
